// File: rtl/tdm_demux14.sv
// Receive-side TDM demultiplexer: recovers frame alignment from sof, collects
// four interleaved channel beats and publishes each complete frame atomically on y.
module tdm_demux14 #(
  parameter int W = 8
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [W-1:0]   din,
  input  logic           din_valid,
  input  logic           sof,
  output logic [4*W-1:0] y,
  output logic           frame_valid,
  output logic           locked,
  output logic           sync_err,
  output logic [1:0]     slot
);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t       state;
  logic [W-1:0] shadow0;
  logic [W-1:0] shadow1;
  logic [W-1:0] shadow2;

  assign locked = (state == RUN);

  // Slot 3 has no shadow: its beat goes straight into y together with the
  // three held channels, so y only ever changes by whole frames.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      slot        <= 2'd0;
      shadow0     <= '0;
      shadow1     <= '0;
      shadow2     <= '0;
      y           <= '0;
      frame_valid <= 1'b0;
      sync_err    <= 1'b0;
    end else begin
      frame_valid <= 1'b0;
      sync_err    <= 1'b0;
      if (din_valid) begin
        case (state)
          IDLE: begin
            if (sof) begin
              shadow0 <= din;
              slot    <= 2'd1;
              state   <= RUN;
            end
          end
          RUN: begin
            if (sof) begin
              // A mid-frame sof realigns; the partial frame is dropped.
              if (slot != 2'd0) begin
                sync_err <= 1'b1;
                shadow1  <= '0;
                shadow2  <= '0;
              end
              shadow0 <= din;
              slot    <= 2'd1;
            end else begin
              case (slot)
                2'd0: shadow0 <= din;
                2'd1: shadow1 <= din;
                2'd2: shadow2 <= din;
                default: begin
                  y           <= {din, shadow2, shadow1, shadow0};
                  frame_valid <= 1'b1;
                end
              endcase
              slot <= slot + 2'd1;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule
